// File: rtl/sys_feed_pkg.sv
// Shared types and sizing helpers for the systolic feed controller.
// Holds the FSM encoding, default array geometry and counter widths.
package sys_feed_pkg;

   localparam int N_DEF       = 4;
   localparam int DW_DEF      = 16;
   localparam int TIMEOUT_DEF = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Number of skewed feed steps for an n x n array.
   function automatic int feed_len(input int n);
      return 2 * n - 1;
   endfunction

   // Bits needed to hold values 0 .. n-1 (never less than 1).
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int FEED_LEN = feed_len(N_DEF);
   localparam int FEED_W   = cnt_w(2 * N_DEF);
   localparam int TO_W     = cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/sys_operand_bank.sv
// N*N x DW operand register file with a combinational skewed reader.
// Ports: clk; we_i/addr_i/data_i write port (row*N+col);
// t_i feed index; lanes_o N lanes, lane l at [l*DW +: DW].
// COL_MAJOR=0: lane l = M[l][t-l]; COL_MAJOR=1: lane l = M[t-l][l].
module sys_operand_bank
   import sys_feed_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int DW        = DW_DEF,
   parameter int IW        = cnt_w(2 * N),
   parameter bit COL_MAJOR = 1'b0
) (
   input  logic                   clk,
   input  logic                   we_i,
   input  logic [$clog2(N*N)-1:0] addr_i,
   input  logic [DW-1:0]          data_i,
   input  logic [IW-1:0]          t_i,
   output logic [N*DW-1:0]        lanes_o
);

   localparam int AW = $clog2(N * N);

   logic [DW-1:0] mem_q [N*N];
   logic [DW-1:0] mem_d [N*N];

   always_comb begin
      mem_d = mem_q;
      if (we_i) mem_d[addr_i] = data_i;
   end

   // Operand contents survive reset on purpose.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      int k;
      logic [AW-1:0] idx;
      k       = 0;
      idx     = '0;
      lanes_o = '0;
      for (int l = 0; l < N; l++) begin
         k = int'(t_i) - l;
         if (k >= 0 && k < N) begin
            if (COL_MAJOR) idx = AW'(k * N + l);
            else           idx = AW'(l * N + k);
            lanes_o[l*DW +: DW] = mem_q[idx];
         end
      end
   end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencer feeding diagonally skewed A/B streams into an N x N array.
// Ports: clk, rst (sync, active high); wr_en/wr_sel/wr_addr/wr_data
// operand load; start; busy; arr_rst; west_o/north_o streams;
// arr_done from array; done_o pulse; err_timeout sticky.
// Option SYS_FEED_PERF_CNT_EN adds perf_cycles (cycles per run).
module systolic_feed_ctrl
   import sys_feed_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   wr_sel,
   input  logic [$clog2(N*N)-1:0] wr_addr,
   input  logic [DW-1:0]          wr_data,
   input  logic                   start,
   output logic                   busy,
   output logic                   arr_rst,
   output logic [N*DW-1:0]        west_o,
   output logic [N*DW-1:0]        north_o,
   input  logic                   arr_done,
   output logic                   done_o,
   output logic                   err_timeout
`ifdef SYS_FEED_PERF_CNT_EN
   ,
   output logic [15:0]            perf_cycles
`endif
);

   localparam int FW = cnt_w(2 * N);
   localparam int TW = cnt_w(TIMEOUT);
   localparam logic [FW-1:0] T_LAST  = FW'(feed_len(N) - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [FW-1:0]   t_q, t_d, rd_t;
   logic [TW-1:0]   dcnt_q, dcnt_d;
   logic [N*DW-1:0] west_q, west_d;
   logic [N*DW-1:0] north_q, north_d;
   logic [N*DW-1:0] a_lanes, b_lanes;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            idle, we_a, we_b;

   assign idle = (state_q == IDLE);
   assign we_a = idle && wr_en && !wr_sel;
   assign we_b = idle && wr_en && wr_sel;

   // Streams are registered, so read one step ahead of t_q.
   assign rd_t = (state_q == CLEAR) ? '0 : t_q + FW'(1);

   sys_operand_bank #(
      .N(N), .DW(DW), .IW(FW), .COL_MAJOR(1'b0)
   ) u_bank_a (
      .clk(clk), .we_i(we_a), .addr_i(wr_addr),
      .data_i(wr_data), .t_i(rd_t), .lanes_o(a_lanes)
   );

   sys_operand_bank #(
      .N(N), .DW(DW), .IW(FW), .COL_MAJOR(1'b1)
   ) u_bank_b (
      .clk(clk), .we_i(we_b), .addr_i(wr_addr),
      .data_i(wr_data), .t_i(rd_t), .lanes_o(b_lanes)
   );

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      dcnt_d  = dcnt_q;
      west_d  = '0;
      north_d = '0;
      done_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               err_d   = 1'b0;
            end
         end
         CLEAR: begin
            state_d = FEED;
            t_d     = '0;
            west_d  = a_lanes;
            north_d = b_lanes;
         end
         FEED: begin
            if (t_q == T_LAST) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end else begin
               t_d     = t_q + FW'(1);
               west_d  = a_lanes;
               north_d = b_lanes;
            end
         end
         DRAIN: begin
            // arr_done wins over a coincident timeout.
            if (arr_done) begin
               state_d = DONE;
            end else if (dcnt_q == TO_LAST) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else begin
               dcnt_d = dcnt_q + TW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         dcnt_q  <= '0;
         west_q  <= '0;
         north_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         dcnt_q  <= dcnt_d;
         west_q  <= west_d;
         north_q <= north_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy        = !idle;
   assign arr_rst     = (state_q == CLEAR);
   assign west_o      = west_q;
   assign north_o     = north_q;
   assign done_o      = done_q;
   assign err_timeout = err_q;

`ifdef SYS_FEED_PERF_CNT_EN
   logic [15:0] run_q, run_d;
   logic [15:0] perf_q, perf_d;

   // run_q counts CLEAR..DONE; DONE latches the total.
   always_comb begin
      run_d  = run_q;
      perf_d = perf_q;
      if (idle) begin
         if (start) begin
            run_d  = 16'd1;
            perf_d = '0;
         end
      end else begin
         if (run_q != 16'hFFFF) run_d = run_q + 16'd1;
         if (state_q == DONE) perf_d = run_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q  <= '0;
         perf_q <= '0;
      end else begin
         run_q  <= run_d;
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule
